bank_readout_scheduler: RTL and testbench
=========================================

BANK_READOUT_SCHEDULER -- requirements
Module: bank_readout_scheduler

Interface
REQ-001 Parameter DEPTH, default 200, words per bank (index range 0..DEPTH-1).
REQ-002 Parameter DW, default 16, sample data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bank0_full  input  1  one-cycle pulse; bank 0 holds DEPTH valid words.
REQ-006 bank1_full  input  1  one-cycle pulse; bank 1 holds DEPTH valid words.
REQ-007 memorization_completed  input  1  one-cycle pulse; partial capture ended in bank done_bank.
REQ-008 done_bank  input  1  bank of the partial capture, sampled with memorization_completed.
REQ-009 idx_final  input  8  last valid index of the partial capture, sampled with memorization_completed.
REQ-010 rd_addr  output  9  RAM read address; bit 8 = bank, bits 7:0 = index.
REQ-011 rd_en  output  1  RAM read strobe; rd_data valid exactly 1 cycle later.
REQ-012 rd_data  input  DW  RAM read data.
REQ-013 out_data  output  DW  streamed sample.
REQ-014 out_valid  output  1  out_data valid.
REQ-015 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-016 out_last  output  1  marks the final word of a job, qualified by out_valid.
REQ-017 out_bank  output  1  bank of the word on out_data.
REQ-018 bank_released  output  2  one-cycle pulse per bank when its last word is accepted.
REQ-019 busy  output  1  high in any state except IDLE or when a job is pending.
REQ-020 overrun  output  1  one-cycle pulse when a job request is dropped.

Function
REQ-021 Job = (bank, length): full pulse gives length DEPTH; memorization_completed gives length min(idx_final, DEPTH-1)+1.
REQ-022 Job queue SHALL be 2 entries, served in arrival order; simultaneous requests queue bank 0 before bank 1.
REQ-023 Request for a bank already queued or being read SHALL be dropped, with overrun pulsed the next cycle.
REQ-024 Simultaneous full pulse and memorization_completed for the same bank: the full-length job is kept; no overrun.
REQ-025 FSM states: IDLE, READ, DRAIN.
REQ-026 IDLE -> READ on the cycle after a queue head exists; the head is popped and the read index loads 0.
REQ-027 READ: rd_en asserted when the output buffer has a free slot counting the in-flight read; the index increments per rd_en.
REQ-028 READ -> DRAIN after the rd_en for index length-1.
REQ-029 DRAIN -> IDLE when the out_last word is accepted; bank_released[bank] pulses the same cycle.
REQ-030 Output buffer SHALL be a 2-entry FIFO; out_valid = buffer non-empty; no word is lost or duplicated under any out_ready pattern.
REQ-031 With out_ready held high, throughput SHALL be 1 word/cycle; the first word is valid 2 cycles after READ is entered.
REQ-032 out_last SHALL be high only on the word with index length-1; out_bank follows the word.
REQ-033 rd_addr SHALL hold its last value when rd_en is low; the index never exceeds DEPTH-1.
REQ-034 A new job SHALL start in IDLE only; back-to-back jobs incur exactly 1 IDLE cycle.

Reset
REQ-035 Reset SHALL force IDLE, empty the queue and output buffer, and drop any in-flight read.
REQ-036 Reset values: rd_addr=0, rd_en=0, out_data=0, out_valid=0, out_last=0, out_bank=0, bank_released=0, busy=0, overrun=0.
REQ-037 Reset asserted mid-job SHALL abandon the job with no bank_released pulse; inputs are ignored while reset is high.

Verification
REQ-038 bank0_full pulse, out_ready=1 -> 200 words at addresses 0x000..0x0C7 on consecutive cycles, out_last on word 199, bank_released=01.
REQ-039 memorization_completed with done_bank=1, idx_final=9 -> 10 words at 0x100..0x109, out_bank=1, out_last on the 10th word, bank_released=10.
REQ-040 bank0_full and bank1_full in the same cycle -> full bank 0 job, 1 IDLE cycle, then full bank 1 job; no overrun.
REQ-041 bank0_full during a bank 0 readout -> overrun pulse for 1 cycle; the current job completes unchanged.
REQ-042 out_ready random 50% during a full job -> exactly 200 accepted words in index order, with no gaps or duplicates.
REQ-043 Reset at word 50 of a job -> all outputs at reset values the next cycle; a following bank1_full runs normally from 0x100.

Source files
------------

// File: rtl/bank_readout_scheduler_if.sv
// bank_readout_scheduler_if: job requests, RAM read port and output stream of the bank readout scheduler
interface bank_readout_scheduler_if #(parameter int DW = 16);
  logic          bank0_full;
  logic          bank1_full;
  logic          memorization_completed;
  logic          done_bank;
  logic [7:0]    idx_final;
  logic [8:0]    rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_bank;
  logic [1:0]    bank_released;
  logic          busy;
  logic          overrun;
  modport slave (
    input  bank0_full, bank1_full, memorization_completed, done_bank, idx_final, rd_data, out_ready,
    output rd_addr, rd_en, out_data, out_valid, out_last, out_bank, bank_released, busy, overrun
  );
  modport master (
    output bank0_full, bank1_full, memorization_completed, done_bank, idx_final, rd_data, out_ready,
    input  rd_addr, rd_en, out_data, out_valid, out_last, out_bank, bank_released, busy, overrun
  );
endinterface

// File: rtl/bank_readout_scheduler.sv
// bank_readout_scheduler: queues per-bank readout jobs and streams RAM words through a 2-entry output FIFO
module bank_readout_scheduler #(
  parameter int DEPTH = 200,
  parameter int DW    = 16
) (
  input logic clk,
  input logic reset,
  bank_readout_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam logic [7:0] LAST = 8'(DEPTH - 1);
  state_t        r_state, w_next;
  logic [1:0]    r_qb, w_qb;
  logic [7:0]    r_ql [2];
  logic [7:0]    w_ql [2];
  logic [1:0]    r_qc, w_qc;
  logic          r_bank;
  logic [7:0]    r_idx, r_last;
  logic [8:0]    r_addr;
  logic          r_inflight, r_if_last, r_if_bank, r_overrun;
  logic [DW+1:0] r_fifo [2];
  logic          r_wp, r_rp;
  logic [1:0]    r_cnt;
  logic [1:0]    w_req, w_held, w_acc;
  logic [7:0]    w_clip, w_len0, w_len1;
  logic          w_start, w_rd_en, w_pop, w_out_last, w_out_bank;
  assign w_pop      = r_cnt != 2'd0 && bus.out_ready;
  assign w_out_last = r_cnt != 2'd0 && r_fifo[r_rp][DW+1];
  assign w_out_bank = r_fifo[r_rp][DW];
  assign w_req      = {bus.bank1_full | (bus.memorization_completed & bus.done_bank),
                       bus.bank0_full | (bus.memorization_completed & ~bus.done_bank)};
  assign w_clip     = bus.idx_final > LAST ? LAST : bus.idx_final;
  assign w_len0     = bus.bank0_full ? LAST : w_clip;
  assign w_len1     = bus.bank1_full ? LAST : w_clip;
  // a bank is busy while queued or owned by the running job, until its last word is accepted
  assign w_held[0]  = (r_qc != 2'd0 && !r_qb[0]) || (r_qc[1] && !r_qb[1]) || (r_state != IDLE && !r_bank);
  assign w_held[1]  = (r_qc != 2'd0 && r_qb[0]) || (r_qc[1] && r_qb[1]) || (r_state != IDLE && r_bank);
  assign w_acc      = w_req & ~w_held;
  assign w_start    = r_state == IDLE && r_qc != 2'd0;
  always_comb begin
    w_rd_en = r_state == READ && (3'(r_cnt) + 3'(r_inflight) - 3'(w_pop)) < 3'd2;
    w_next  = w_start ? READ
            : (r_state == READ && w_rd_en && r_idx == r_last) ? DRAIN
            : (r_state == DRAIN && w_pop && w_out_last) ? IDLE : r_state;
  end
  // pop first, then append; a bank can be queued only once, so pushes always fit
  always_comb begin
    w_qb = r_qb;
    w_ql = r_ql;
    w_qc = r_qc;
    if (w_start) begin
      w_qb[0] = r_qb[1];
      w_ql[0] = r_ql[1];
      w_qc    = r_qc - 2'd1;
    end
    if (w_acc[0]) begin
      w_qb[w_qc[0]] = 1'b0;
      w_ql[w_qc[0]] = w_len0;
      w_qc          = w_qc + 2'd1;
    end
    if (w_acc[1]) begin
      w_qb[w_qc[0]] = 1'b1;
      w_ql[w_qc[0]] = w_len1;
      w_qc          = w_qc + 2'd1;
    end
  end
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qb       <= '0;
      r_ql       <= '{default: '0};
      r_qc       <= '0;
      r_bank     <= 1'b0;
      r_idx      <= '0;
      r_last     <= '0;
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_if_last  <= 1'b0;
      r_if_bank  <= 1'b0;
      r_overrun  <= 1'b0;
      r_fifo     <= '{default: '0};
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_qb       <= w_qb;
      r_ql       <= w_ql;
      r_qc       <= w_qc;
      r_overrun  <= |(w_req & w_held);
      if (w_start) begin
        r_bank <= r_qb[0];
        r_last <= r_ql[0];
        r_idx  <= '0;
      end else if (w_rd_en && r_idx != r_last) r_idx <= r_idx + 8'd1;
      if (w_rd_en) r_addr <= {r_bank, r_idx};
      r_inflight <= w_rd_en;
      r_if_last  <= w_rd_en && r_idx == r_last;
      r_if_bank  <= r_bank;
      if (r_inflight) begin
        r_fifo[r_wp] <= {r_if_last, r_if_bank, bus.rd_data};
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end
  assign bus.rd_en         = w_rd_en;
  assign bus.rd_addr       = w_rd_en ? {r_bank, r_idx} : r_addr;
  assign bus.out_valid     = r_cnt != 2'd0;
  assign bus.out_data      = r_fifo[r_rp][DW-1:0];
  assign bus.out_bank      = w_out_bank;
  assign bus.out_last      = w_out_last;
  assign bus.bank_released = {2{w_pop && w_out_last}} & {w_out_bank, ~w_out_bank};
  assign bus.busy          = r_state != IDLE || r_qc != 2'd0;
  assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_bank_readout_scheduler.sv
// tb_bank_readout_scheduler: randomized and directed checks against a job/word-stream reference model
module tb_bank_readout_scheduler;
  localparam int DEPTH = 200;
  localparam int DW    = 16;
  typedef struct {logic [8:0] addr; logic last;} word_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rand_ready = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  word_t exp_q[$];
  logic [8:0] rd_q[$];
  logic [8:0] last_addr = '0;
  logic [1:0] held = '0;
  logic exp_ovr = 1'b0;
  word_t w;
  logic [8:0] a;
  logic r0, r1;
  always #5 clk = ~clk;
  bank_readout_scheduler_if #(.DW(DW)) bif();
  bank_readout_scheduler #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bif));
  function automatic logic [DW-1:0] ram(input logic [8:0] ad);
    return DW'(32'(ad) * 32'd40503 ^ 32'h5A5A);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic add_job(input logic b, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{addr: {b, 8'(i)}, last: i == len - 1});
      rd_q.push_back({b, 8'(i)});
    end
    held[b] = 1'b1;
  endtask
  function automatic int job_len(input logic full);
    if (full) return DEPTH;
    return bif.idx_final > 8'(DEPTH - 1) ? DEPTH : int'(bif.idx_final) + 1;
  endfunction
  always @(posedge clk) bif.rd_data <= bif.rd_en ? ram(bif.rd_addr) : DW'($urandom);
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rd_q.delete();
      held = '0;
      exp_ovr = 1'b0;
      last_addr = '0;
    end else begin
      chk("overrun", bif.overrun, exp_ovr);
      r0 = bif.bank0_full | (bif.memorization_completed & ~bif.done_bank);
      r1 = bif.bank1_full | (bif.memorization_completed & bif.done_bank);
      exp_ovr = (r0 & held[0]) | (r1 & held[1]);
      if (r0 && !held[0]) add_job(1'b0, job_len(bif.bank0_full));
      if (r1 && !held[1]) add_job(1'b1, job_len(bif.bank1_full));
      if (bif.rd_en) begin
        if (rd_q.size() == 0) chk("rd_extra", 1, 0);
        else begin
          a = rd_q.pop_front();
          chk("rd_addr", bif.rd_addr, a);
          last_addr = a;
        end
      end else chk("rd_hold", bif.rd_addr, last_addr);
      if (bif.out_valid && bif.out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) chk("out_extra", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("out_data", bif.out_data, ram(w.addr));
          chk("out_bank", bif.out_bank, w.addr[8]);
          chk("out_last", bif.out_last, w.last);
          chk("released", bif.bank_released, w.last ? (w.addr[8] ? 2'b10 : 2'b01) : 2'b00);
          if (w.last) held[w.addr[8]] = 1'b0;
        end
      end else chk("released_idle", bif.bank_released, 0);
    end
  end
  initial begin
    bif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rd_addr", bif.rd_addr, 0);
    chk("rst_rd_en", bif.rd_en, 0);
    chk("rst_out_data", bif.out_data, 0);
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_out_last", bif.out_last, 0);
    chk("rst_out_bank", bif.out_bank, 0);
    chk("rst_released", bif.bank_released, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_overrun", bif.overrun, 0);
    reset = 1'b0;
  endtask
  task automatic pulse(input logic b0, input logic b1, input logic mc, input logic db, input logic [7:0] idx);
    bif.bank0_full = b0;
    bif.bank1_full = b1;
    bif.memorization_completed = mc;
    bif.done_bank = db;
    bif.idx_final = idx;
    @(posedge clk);
    #1;
    bif.bank0_full = 1'b0;
    bif.bank1_full = 1'b0;
    bif.memorization_completed = 1'b0;
  endtask
  task automatic time_release(input int start, output int n);
    n = start;
    do begin
      @(negedge clk);
      n++;
    end while (bif.bank_released == 2'b00 && n < 3000);
  endtask
  task automatic wait_done(input int budget, input logic idle);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
    if (idle) chk("busy_idle", bif.busy, 0);
  endtask
  initial begin
    int n, base;
    bif.bank0_full = 1'b0;
    bif.bank1_full = 1'b0;
    bif.memorization_completed = 1'b0;
    bif.done_bank = 1'b0;
    bif.idx_final = '0;
    @(posedge clk);
    #1 do_reset();
    repeat (2) @(posedge clk);
    #1 pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    time_release(0, n);
    chk("lat_full_b0", n, 203);
    wait_done(50, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 8'd9);
    time_release(0, n);
    chk("lat_partial_b1", n, 13);
    wait_done(50, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    time_release(0, n);
    chk("lat_pair_b0", n, 203);
    time_release(n, n);
    chk("lat_pair_b1", n, 406);
    wait_done(50, 1'b1);
    pulse(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    time_release(0, n);
    chk("lat_full_wins", n, 203);
    wait_done(50, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'd250);
    time_release(0, n);
    chk("lat_clip", n, 203);
    wait_done(50, 1'b1);
    base = acc_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (30) @(posedge clk);
    #1 pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("overrun_pulse", bif.overrun, 1);
    @(posedge clk);
    #1 chk("overrun_clear", bif.overrun, 0);
    wait_done(400, 1'b1);
    chk("overrun_words", acc_cnt - base, 200);
    rand_ready = 1'b1;
    base = acc_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_done(3000, 1'b0);
    chk("rand_ready_words", acc_cnt - base, 200);
    rand_ready = 1'b0;
    @(posedge clk);
    #1 base = acc_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    n = 0;
    while (acc_cnt - base < 50 && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reach_word50", acc_cnt - base, 50);
    do_reset();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    time_release(0, n);
    chk("lat_after_reset", n, 203);
    wait_done(50, 1'b1);
    rand_ready = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      int r = int'($urandom_range(0, 99));
      bif.bank0_full = r == 0;
      bif.bank1_full = r == 1;
      bif.memorization_completed = r >= 2 && r < 9;
      bif.done_bank = 1'($urandom_range(0, 1));
      bif.idx_final = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 30));
      @(posedge clk);
      #1;
    end
    bif.bank0_full = 1'b0;
    bif.bank1_full = 1'b0;
    bif.memorization_completed = 1'b0;
    wait_done(8000, 1'b0);
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("final_busy", bif.busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
